// File: rtl/mips_bus_arbiter_pkg.sv
// mips_bus_pkg: shared types for the MIPS bus arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state enum, grant enum, full-word byte-enable constant.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INST = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Byte enables for a full 32-bit word (instruction fetches).
  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// mips_bus_arbiter_if: bundles the fetch port, data port and Avalon master pins.
// Latency: n/a (wires only).
// Backpressure: waitrequest stalls the Avalon side; requesters hold req until ack.
//
// Modports:
//   master - the arbiter's view (drives acks, read data, Avalon command, busy)
//   slave  - the environment's view (CPU requesters plus the Avalon slave)
interface mips_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Instruction-fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  // Load/store requester
  logic                d_req;
  logic                d_write;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_byteenable;
  logic                d_ack;
  logic [DATA_W-1:0]   d_rdata;

  // Avalon-MM master pins
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;

  logic busy;

  modport master (
    input  i_req, i_addr,
    input  d_req, d_write, d_addr, d_wdata, d_byteenable,
    input  waitrequest, readdata,
    output i_ack, i_rdata, d_ack, d_rdata,
    output address, read, write, writedata, byteenable,
    output busy
  );

  modport slave (
    output i_req, i_addr,
    output d_req, d_write, d_addr, d_wdata, d_byteenable,
    output waitrequest, readdata,
    input  i_ack, i_rdata, d_ack, d_rdata,
    input  address, read, write, writedata, byteenable,
    input  busy
  );

endinterface

// File: rtl/mips_bus_arbiter_arb_select.sv
// arb_select: combinational tie-breaker between fetch and data requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller only uses grant while in IDLE.
//
// Ports: elig_i/elig_d (eligible requests), last_grant (previous winner),
//        grant_vld (some request eligible), grant (winner).
module arb_select
  import mips_bus_pkg::*;
#(
  parameter int DATA_PRIORITY = 1
) (
  input  logic   elig_i,
  input  logic   elig_d,
  input  grant_t last_grant,
  output logic   grant_vld,
  output grant_t grant
);

  always_comb begin
    grant_vld = elig_i | elig_d;
    grant     = GRANT_D;
    if (elig_i && !elig_d) begin
      grant = GRANT_I;
    end else if (elig_i && elig_d && (DATA_PRIORITY == 0) && (last_grant == GRANT_D)) begin
      // Round-robin: on a tie hand the bus to whoever did not win last time.
      grant = GRANT_I;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: shares one Avalon-MM master between fetch and load/store ports.
// Latency: request sampled cycle N, command from N+1, ack in N+2 plus one per waitrequest cycle.
// Backpressure: command held stable while waitrequest=1; requesters hold req until their ack.
//
// Ports: clk, reset (async active-high), bus (mips_bus_arbiter_if.master):
//   fetch port i_*, data port d_*, Avalon pins, busy.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int DATA_PRIORITY = 1,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32
) (
  input  logic               clk,
  input  logic               reset,
  mips_bus_arbiter_if.master bus
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_FETCH = (BE_W == 4) ? BE_W'(BE_WORD) : {BE_W{1'b1}};

  arb_state_t state;
  grant_t     last_grant;

  // A requester whose ack is visible this cycle is masked, so a held request
  // is not re-granted before the other port gets a turn.
  logic   elig_i;
  logic   elig_d;
  logic   grant_vld;
  grant_t grant;

  assign elig_i = bus.i_req & ~bus.i_ack;
  assign elig_d = bus.d_req & ~bus.d_ack;

  arb_select #(
    .DATA_PRIORITY(DATA_PRIORITY)
  ) u_arb_select (
    .elig_i    (elig_i),
    .elig_d    (elig_d),
    .last_grant(last_grant),
    .grant_vld (grant_vld),
    .grant     (grant)
  );

  // Command selected from the winning port.
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [BE_W-1:0]   cmd_be;
  logic              cmd_rd;
  logic              cmd_wr;

  always_comb begin
    cmd_addr  = bus.i_addr;
    cmd_wdata = '0;
    cmd_be    = BE_FETCH;
    cmd_rd    = 1'b1;
    cmd_wr    = 1'b0;
    if (grant == GRANT_D) begin
      cmd_addr  = bus.d_addr;
      cmd_wdata = bus.d_wdata;
      cmd_be    = bus.d_byteenable;
      cmd_rd    = ~bus.d_write;
      cmd_wr    = bus.d_write;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ARB_IDLE;
      last_grant     <= GRANT_D;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.i_ack      <= 1'b0;
      bus.d_ack      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.address    <= '0;
      bus.writedata  <= '0;
      bus.byteenable <= '0;
      bus.i_rdata    <= '0;
      bus.d_rdata    <= '0;
    end else begin
      // Acks are single-cycle pulses.
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_vld) begin
            bus.address    <= cmd_addr;
            bus.writedata  <= cmd_wdata;
            bus.byteenable <= cmd_be;
            bus.read       <= cmd_rd;
            bus.write      <= cmd_wr;
            bus.busy       <= 1'b1;
            last_grant     <= grant;
            state          <= (grant == GRANT_D) ? ARB_DATA : ARB_INST;
          end
        end
        ARB_INST: begin
          if (!bus.waitrequest) begin
            bus.i_rdata <= bus.readdata;
            bus.i_ack   <= 1'b1;
            bus.read    <= 1'b0;
            bus.write   <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= ARB_IDLE;
          end
        end
        ARB_DATA: begin
          if (!bus.waitrequest) begin
            // Stores leave the load-data register untouched.
            if (bus.read) begin
              bus.d_rdata <= bus.readdata;
            end
            bus.d_ack <= 1'b1;
            bus.read  <= 1'b0;
            bus.write <= 1'b0;
            bus.busy  <= 1'b0;
            state     <= ARB_IDLE;
          end
        end
        default: begin
          state     <= ARB_IDLE;
          bus.read  <= 1'b0;
          bus.write <= 1'b0;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
